dm_access_sequencer: RTL
========================

// Module: dm_access_sequencer
// PURPOSE
//  Multi-cycle sequencer between the execute-stage data-memory controls (dm_wvalid / dm_op_data) and a
//  valid/ready data-memory bus. Issues one request per load/store, generates byte strobes,
//  aligns and extends load data, and stalls the core until the access completes or times out.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max RSP-state wait before abort; range 1..255, 8-bit counter
// PORTS
//  i_clk            in   1   clock
//  i_rst            in   1   asynchronous reset, active-high
//  i_eu_dm_req      in   1   load/store present in execute
//  i_eu_dm_wvalid   in   1   1=store, 0=load
//  i_eu_dm_op_data  in   3   size: 000 B, 001 H, 010 W, 100 BU, 101 HU (funct3 coding)
//  i_eu_dm_addr     in   32  byte address (ALU result)
//  i_eu_dm_wdata    in   32  store data (rs2)
//  o_core_stall     out  1   hold PC/pipeline
//  o_eu_dm_rdata    out  32  extended load data, valid with o_eu_dm_rvalid
//  o_eu_dm_rvalid   out  1   one-cycle pulse, load complete
//  o_dm_err         out  1   one-cycle pulse, response timeout
//  o_dm_misalign    out  1   one-cycle pulse, misaligned access (see CONFIGURATION)
//  o_dm_req_valid   out  1   bus request valid
//  i_dm_req_ready   in   1   bus request accepted
//  o_dm_req_we      out  1   bus write enable
//  o_dm_req_addr    out  32  word-aligned address, [1:0]=0
//  o_dm_req_wdata   out  32  lane-replicated store data
//  o_dm_req_wstrb   out  4   byte strobes; 0000 for loads
//  i_dm_rsp_valid   in   1   read data valid
//  i_dm_rsp_data    in   32  read word
//  o_dm_rsp_ready   out  1   high only in RSP
// BEHAVIOUR
//  Reset: state IDLE, every output 0, timeout counter 0. Reset is asynchronous; mid-access it drops
//   o_dm_req_valid immediately and discards any capture.
//  FSM IDLE->REQ->(RSP)->DONE->IDLE:
//   IDLE: if i_eu_dm_req, register addr/wdata/op/we and go to REQ.
//   REQ:  o_dm_req_valid=1. Hold valid, addr, we, wdata and wstrb stable until i_dm_req_ready.
//         On ready: store->DONE; load->RSP.
//   RSP:  o_dm_rsp_ready=1, counter++. On i_dm_rsp_valid: capture extended data->DONE.
//         When counter reaches TIMEOUT_CYCLES without valid: rdata=0 and o_dm_err pulses in DONE.
//   DONE: stall=0; o_eu_dm_rvalid=1 for a load; ignore i_eu_dm_req (same instr); go to IDLE.
//  o_core_stall = (IDLE & i_eu_dm_req) | REQ | RSP (combinational).
//  Latency with zero wait states: store stalls 2 cycles, load stalls 3 cycles.
//  Response and ready in the same cycle as REQ exit are not possible; RSP is entered first.
//  Strobes, with a = addr[1:0]:
//   B: wstrb = 0001<<a, wdata = {4{b}}.
//   H: wstrb = 0011<<(2*a[1]), wdata = {2{h}}.
//   W: wstrb = 1111.
//  Load: shift rsp_data right by 8*a (H uses a[1]). Sign-extend for B/H, zero-extend for BU/HU.
//  A response arriving outside RSP is ignored. Unused op codes are treated as W.
// CONFIGURATION
//  DM_MISALIGN_TRAP_EN defined:
//   Misaligned H (a[0]=1) or W (a!=0) in IDLE goes straight to DONE. No bus request, no write.
//   rdata=0, o_dm_misalign pulses in DONE, stall lasts 1 cycle.
//  Undefined: low address bits are forced aligned (H clears a[0], W clears a); o_dm_misalign tied 0.
// TESTING
//  SW 0xDEADBEEF @0x100, ready=1 -> addr 0x100, wstrb 1111, we=1, stall 2 cycles, no rvalid.
//  LB @0x203, rsp 0x80FFFF00 -> rdata 0xFFFFFF80. LBU same -> 0x00000080. Each with 1-cycle rvalid.
//  SH 0x0000ABCD @0x12 -> addr 0x10, wstrb 1100, wdata 0xABCDABCD.
//  Store with ready low 5 cycles -> valid/addr/wdata/wstrb stable, stall held 6+1 cycles.
//  TIMEOUT_CYCLES=16, load, rsp never valid -> o_dm_err pulse after 16 RSP cycles, rdata 0, stall released.
//  i_rst pulse in RSP -> outputs 0 asynchronously, FSM IDLE.
//  With DM_MISALIGN_TRAP_EN, LW @0x101 -> o_dm_misalign pulse, req_valid never asserted.

Source files
------------

// File: rtl/dm_access_sequencer.sv
// dm_access_sequencer: sequences one valid/ready bus access per execute-stage load/store, stalling the core until done.
// Optional DM_MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of forcing them aligned.
module dm_access_sequencer #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_eu_dm_req,
   input  logic        i_eu_dm_wvalid,
   input  logic [2:0]  i_eu_dm_op_data,
   input  logic [31:0] i_eu_dm_addr,
   input  logic [31:0] i_eu_dm_wdata,
   output logic        o_core_stall,
   output logic [31:0] o_eu_dm_rdata,
   output logic        o_eu_dm_rvalid,
   output logic        o_dm_err,
   output logic        o_dm_misalign,
   output logic        o_dm_req_valid,
   input  logic        i_dm_req_ready,
   output logic        o_dm_req_we,
   output logic [31:0] o_dm_req_addr,
   output logic [31:0] o_dm_req_wdata,
   output logic [3:0]  o_dm_req_wstrb,
   input  logic        i_dm_rsp_valid,
   input  logic [31:0] i_dm_rsp_data,
   output logic        o_dm_rsp_ready
);
   typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;
   state_t      r_state, w_next;
   logic [31:0] r_addr, r_wdata, r_rdata, w_wdata, w_shift, w_ext;
   logic [3:0]  r_wstrb, w_wstrb;
   logic [2:0]  r_op;
   logic [1:0]  r_lo, w_lo, w_a;
   logic [7:0]  r_cnt;
   logic        r_we, r_err, r_mis, w_byte, w_half, w_trap, w_tmo, w_capture;

   assign w_a    = i_eu_dm_addr[1:0];
   assign w_byte = i_eu_dm_op_data[1:0] == 2'b00;
   assign w_half = i_eu_dm_op_data[1:0] == 2'b01;
   // Lane offset after alignment to the access size; unused op codes fall through to word
   assign w_lo   = w_byte ? w_a : w_half ? {w_a[1], 1'b0} : 2'b00;
`ifdef DM_MISALIGN_TRAP_EN
   assign w_trap = w_lo != w_a;
`else
   assign w_trap = 1'b0;
`endif
   assign w_wstrb   = !i_eu_dm_wvalid ? 4'b0000 : w_byte ? 4'b0001 << w_a : w_half ? 4'b0011 << w_lo : 4'b1111;
   assign w_wdata   = w_byte ? {4{i_eu_dm_wdata[7:0]}} : w_half ? {2{i_eu_dm_wdata[15:0]}} : i_eu_dm_wdata;
   assign w_capture = r_state == IDLE && i_eu_dm_req;
   assign w_tmo     = r_cnt == 8'(TIMEOUT_CYCLES - 1);
   assign w_shift   = i_dm_rsp_data >> {r_lo, 3'b000};
   assign w_ext     = r_op[1:0] == 2'b00 ? {{24{~r_op[2] & w_shift[7]}}, w_shift[7:0]} :
                      r_op[1:0] == 2'b01 ? {{16{~r_op[2] & w_shift[15]}}, w_shift[15:0]} : w_shift;

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) r_state <= IDLE;
      else r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = !i_eu_dm_req ? IDLE : w_trap ? DONE : REQ;
         REQ:     w_next = !i_dm_req_ready ? REQ : r_we ? DONE : RSP;
         RSP:     w_next = (i_dm_rsp_valid || w_tmo) ? DONE : RSP;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      o_core_stall   = !i_rst && (w_capture || r_state == REQ || r_state == RSP);
      o_dm_req_valid = r_state == REQ;
      o_dm_rsp_ready = r_state == RSP;
      o_eu_dm_rvalid = r_state == DONE && !r_we;
      o_dm_err       = r_state == DONE && r_err;
      o_dm_misalign  = r_state == DONE && r_mis;
      o_dm_req_we    = r_we;
      o_dm_req_addr  = r_addr;
      o_dm_req_wdata = r_wdata;
      o_dm_req_wstrb = r_wstrb;
      o_eu_dm_rdata  = r_rdata;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
         r_op    <= '0;
         r_lo    <= '0;
         r_we    <= 1'b0;
         r_mis   <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
         r_cnt   <= '0;
      end else begin
         r_cnt <= r_state == RSP ? r_cnt + 8'd1 : 8'd0;
         if (w_capture) begin
            r_addr  <= {i_eu_dm_addr[31:2], 2'b00};
            r_wdata <= w_wdata;
            r_wstrb <= w_wstrb;
            r_op    <= i_eu_dm_op_data;
            r_lo    <= w_lo;
            r_we    <= i_eu_dm_wvalid;
            r_mis   <= w_trap;
            r_err   <= 1'b0;
            r_rdata <= '0;
         end
         if (r_state == RSP && i_dm_rsp_valid) r_rdata <= w_ext;
         else if (r_state == RSP && w_tmo) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
         end
      end
   end
endmodule
